// File: rtl/fei4_rx_frame_assembler_pkg.sv
// Shared definitions for the FE-I4 receiver frame assembler: comma symbols,
// FSM state encoding and record geometry.
package fei4_rx_pkg;

    // Decoded symbols are {K flag, byte}
    localparam logic [8:0] K28_7_SOF  = 9'h1FC;
    localparam logic [8:0] K28_5_EOF  = 9'h1BC;
    localparam logic [8:0] K28_1_IDLE = 9'h13C;

    localparam int REC_WIDTH = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } asm_state_t;

    // True when the symbol is a control (K) character
    function automatic logic is_k_symbol(input logic [8:0] sym);
        return sym[8];
    endfunction

endpackage

// File: rtl/fei4_rx_frame_assembler_if.sv
// Record channel from the frame assembler to the receiver FIFO.
interface fei4_rx_frame_assembler_if;
    import fei4_rx_pkg::*;

    logic [REC_WIDTH-1:0] rec_data;
    logic                 rec_first;
    logic                 rec_valid;
    logic                 rec_ready;

    modport master (
        output rec_data,
        output rec_first,
        output rec_valid,
        input  rec_ready
    );

    modport slave (
        input  rec_data,
        input  rec_first,
        input  rec_valid,
        output rec_ready
    );

endinterface

// File: rtl/fei4_rx_frame_assembler_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    // Count events, stick at all-ones, clear on request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fei4_rx_frame_assembler.sv
// FE-I4 frame assembler: turns the decoded symbol stream into 24-bit records
// delimited by SOF/EOF commas, with a single-entry output register and
// saturating error counters for slow control.
module fei4_rx_frame_assembler
    import fei4_rx_pkg::*;
#(
    parameter int CNT_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       sym_valid,
    input  logic [8:0]                 sym_data,
    input  logic                       sym_code_err,
    input  logic                       sym_disp_err,
    fei4_rx_frame_assembler_if.master  rec,
    input  logic                       clear_cnt,
    output logic [CNT_WIDTH-1:0]       dec_err_cnt,
    output logic [CNT_WIDTH-1:0]       frame_err_cnt,
    output logic [CNT_WIDTH-1:0]       lost_cnt
);

    asm_state_t           state_q, state_next;
    logic [1:0]           bidx_q, bidx_next;
    logic [15:0]          partial_q, partial_next;
    logic                 first_pending_q, first_pending_next;

    logic                 rec_form;
    logic [REC_WIDTH-1:0] rec_form_data;
    logic                 rec_form_first;
    logic                 dec_err_inc;
    logic                 frame_err_inc;
    logic                 rec_load;
    logic                 lost_inc;

    logic [REC_WIDTH-1:0] rec_data_q;
    logic                 rec_first_q;
    logic                 rec_valid_q;

    logic [7:0]           sym_byte;
    logic                 sym_bad;

    assign sym_byte = sym_data[7:0];
    assign sym_bad  = sym_code_err | sym_disp_err;

    // FSM state, byte index and partial bytes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            bidx_q          <= 2'd0;
            partial_q       <= 16'h0000;
            first_pending_q <= 1'b0;
        end else begin
            state_q         <= state_next;
            bidx_q          <= bidx_next;
            partial_q       <= partial_next;
            first_pending_q <= first_pending_next;
        end
    end

    // Symbol interpretation: framing transitions, record formation, error events
    always_comb begin
        state_next         = state_q;
        bidx_next          = bidx_q;
        partial_next       = partial_q;
        first_pending_next = first_pending_q;
        rec_form           = 1'b0;
        rec_form_data      = '0;
        rec_form_first     = 1'b0;
        dec_err_inc        = 1'b0;
        frame_err_inc      = 1'b0;

        if (!enable) begin
            state_next         = ST_IDLE;
            bidx_next          = 2'd0;
            first_pending_next = 1'b0;
        end else if (sym_valid) begin
            if (sym_bad) begin
                dec_err_inc = 1'b1;
                if (state_q == ST_FRAME) begin
                    state_next         = ST_IDLE;
                    bidx_next          = 2'd0;
                    first_pending_next = 1'b0;
                end
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (sym_data == K28_7_SOF) begin
                            state_next         = ST_FRAME;
                            bidx_next          = 2'd0;
                            first_pending_next = 1'b1;
                        end
                    end
                    ST_FRAME: begin
                        if (!is_k_symbol(sym_data)) begin
                            case (bidx_q)
                                2'd0: begin
                                    partial_next[15:8] = sym_byte;
                                    bidx_next          = 2'd1;
                                end
                                2'd1: begin
                                    partial_next[7:0] = sym_byte;
                                    bidx_next         = 2'd2;
                                end
                                default: begin
                                    rec_form           = 1'b1;
                                    rec_form_data      = {partial_q, sym_byte};
                                    rec_form_first     = first_pending_q;
                                    first_pending_next = 1'b0;
                                    bidx_next          = 2'd0;
                                end
                            endcase
                        end else if (sym_data == K28_7_SOF) begin
                            // A new SOF abandons the current frame and restarts
                            frame_err_inc      = 1'b1;
                            bidx_next          = 2'd0;
                            first_pending_next = 1'b1;
                        end else if (sym_data == K28_5_EOF) begin
                            frame_err_inc      = (bidx_q != 2'd0);
                            state_next         = ST_IDLE;
                            bidx_next          = 2'd0;
                            first_pending_next = 1'b0;
                        end else begin
                            frame_err_inc      = 1'b1;
                            state_next         = ST_IDLE;
                            bidx_next          = 2'd0;
                            first_pending_next = 1'b0;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A formed record fits if the register is empty or draining this cycle
    always_comb begin
        rec_load = rec_form && (!rec_valid_q || rec.rec_ready);
        lost_inc = rec_form && !rec_load;
    end

    // Single-entry output register; contents frozen while valid and not accepted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rec_data_q  <= '0;
            rec_first_q <= 1'b0;
            rec_valid_q <= 1'b0;
        end else if (rec_load) begin
            rec_data_q  <= rec_form_data;
            rec_first_q <= rec_form_first;
            rec_valid_q <= 1'b1;
        end else if (rec_valid_q && rec.rec_ready) begin
            rec_valid_q <= 1'b0;
        end
    end

    assign rec.rec_data  = rec_data_q;
    assign rec.rec_first = rec_first_q;
    assign rec.rec_valid = rec_valid_q;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_dec_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (dec_err_inc),
        .clr   (clear_cnt),
        .count (dec_err_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (frame_err_inc),
        .clr   (clear_cnt),
        .count (frame_err_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_lost_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lost_inc),
        .clr   (clear_cnt),
        .count (lost_cnt)
    );

endmodule

// File: tb/tb_fei4_rx_frame_assembler.sv
// Bench for fei4_rx_frame_assembler: directed scenarios plus a randomized
// stream compared cycle by cycle against a queue-based frame model.
module tb_fei4_rx_frame_assembler;
    import fei4_rx_pkg::*;

    localparam logic [8:0] UNK_K = 9'h1F7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       sym_valid;
    logic [8:0] sym_data;
    logic       sym_code_err;
    logic       sym_disp_err;
    logic       clear_cnt;
    logic [7:0] dec_err_cnt;
    logic [7:0] frame_err_cnt;
    logic [7:0] lost_cnt;

    fei4_rx_frame_assembler_if rec_bus ();

    fei4_rx_frame_assembler #(.CNT_WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sym_valid     (sym_valid),
        .sym_data      (sym_data),
        .sym_code_err  (sym_code_err),
        .sym_disp_err  (sym_disp_err),
        .rec           (rec_bus),
        .clear_cnt     (clear_cnt),
        .dec_err_cnt   (dec_err_cnt),
        .frame_err_cnt (frame_err_cnt),
        .lost_cnt      (lost_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit         m_in_frame;
    bit         m_first;
    logic [7:0] m_bytes[$];
    bit         m_hold;
    logic [23:0] m_rec_data;
    bit         m_rec_first;
    logic [7:0] m_dec;
    logic [7:0] m_frame;
    logic [7:0] m_lost;

    task automatic model_reset();
        m_in_frame  = 0;
        m_first     = 0;
        m_bytes.delete();
        m_hold      = 0;
        m_rec_data  = 24'h0;
        m_rec_first = 0;
        m_dec       = 8'd0;
        m_frame     = 8'd0;
        m_lost      = 8'd0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample after it
    task automatic step(input bit en, input bit sv, input logic [8:0] sym,
                        input bit ce, input bit de, input bit rdy, input bit clr);
        bit formed, f_first, d_inc, f_inc, l_inc;
        logic [23:0] f_data;
        enable            = en;
        sym_valid         = sv;
        sym_data          = sym;
        sym_code_err      = ce;
        sym_disp_err      = de;
        rec_bus.rec_ready = rdy;
        clear_cnt         = clr;
        @(posedge clk);
        formed = 0; f_first = 0; f_data = 24'h0;
        d_inc = 0; f_inc = 0; l_inc = 0;
        if (!en) begin
            m_in_frame = 0;
            m_bytes.delete();
        end else if (sv) begin
            if (ce || de) begin
                d_inc = 1;
                if (m_in_frame) begin
                    m_in_frame = 0;
                    m_bytes.delete();
                end
            end else if (!m_in_frame) begin
                if (sym == K28_7_SOF) begin
                    m_in_frame = 1;
                    m_first    = 1;
                    m_bytes.delete();
                end
            end else if (sym[8] == 1'b0) begin
                m_bytes.push_back(sym[7:0]);
                if (m_bytes.size() == 3) begin
                    formed  = 1;
                    f_data  = {m_bytes[0], m_bytes[1], m_bytes[2]};
                    f_first = m_first;
                    m_first = 0;
                    m_bytes.delete();
                end
            end else if (sym == K28_7_SOF) begin
                f_inc   = 1;
                m_first = 1;
                m_bytes.delete();
            end else if (sym == K28_5_EOF) begin
                f_inc      = (m_bytes.size() != 0);
                m_in_frame = 0;
                m_bytes.delete();
            end else begin
                f_inc      = 1;
                m_in_frame = 0;
                m_bytes.delete();
            end
        end
        if (m_hold && rdy) m_hold = 0;
        if (formed) begin
            if (!m_hold) begin
                m_hold      = 1;
                m_rec_data  = f_data;
                m_rec_first = f_first;
            end else begin
                l_inc = 1;
            end
        end
        if (clr) begin
            m_dec = 0; m_frame = 0; m_lost = 0;
        end else begin
            if (d_inc && m_dec   != 8'hFF) m_dec++;
            if (f_inc && m_frame != 8'hFF) m_frame++;
            if (l_inc && m_lost  != 8'hFF) m_lost++;
        end
        #1;
    endtask

    task automatic sym_step(input logic [8:0] sym, input bit rdy);
        step(1'b1, 1'b1, sym, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic idle_step(input bit rdy);
        step(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic clear_counters();
        step(1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b0; sym_valid = 1'b0; sym_data = 9'h0;
        sym_code_err = 1'b0; sym_disp_err = 1'b0;
        rec_bus.rec_ready = 1'b0; clear_cnt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if ({rec_bus.rec_valid, rec_bus.rec_first, rec_bus.rec_data} !== 26'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_rec: valid=%0b first=%0b data=%06h required all 0",
                     rec_bus.rec_valid, rec_bus.rec_first, rec_bus.rec_data);
        end
        n_checks++;
        if ({dec_err_cnt, frame_err_cnt, lost_cnt} !== 24'h0) begin
            n_errors++;
            $display("[TB] FAIL reset_cnt: dec=%0d frame=%0d lost=%0d required 0",
                     dec_err_cnt, frame_err_cnt, lost_cnt);
        end
        rst_n = 1'b1;
        idle_step(1'b1);
    endtask

    task automatic test_two_records();
        logic [8:0] seq[8];
        seq = '{K28_7_SOF, 9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066, K28_5_EOF};
        for (int i = 0; i < 8; i++) begin
            sym_step(seq[i], 1'b1);
            if (i == 3) begin
                n_checks++;
                if (rec_bus.rec_valid !== 1'b1 || rec_bus.rec_data !== 24'h112233 ||
                    rec_bus.rec_first !== 1'b1) begin
                    n_errors++;
                    $display("[TB] FAIL rec0: valid=%0b data=%06h first=%0b required 1 112233 1",
                             rec_bus.rec_valid, rec_bus.rec_data, rec_bus.rec_first);
                end
            end else if (i == 6) begin
                n_checks++;
                if (rec_bus.rec_valid !== 1'b1 || rec_bus.rec_data !== 24'h445566 ||
                    rec_bus.rec_first !== 1'b0) begin
                    n_errors++;
                    $display("[TB] FAIL rec1: valid=%0b data=%06h first=%0b required 1 445566 0",
                             rec_bus.rec_valid, rec_bus.rec_data, rec_bus.rec_first);
                end
            end else if (i != 0) begin
                n_checks++;
                if (rec_bus.rec_valid !== 1'b0) begin
                    n_errors++;
                    $display("[TB] FAIL no_rec_%0d: valid=%0b required 0", i, rec_bus.rec_valid);
                end
            end
        end
        n_checks++;
        if ({dec_err_cnt, frame_err_cnt, lost_cnt} !== 24'h0) begin
            n_errors++;
            $display("[TB] FAIL clean_cnt: dec=%0d frame=%0d lost=%0d required 0",
                     dec_err_cnt, frame_err_cnt, lost_cnt);
        end
    endtask

    task automatic test_short_frame();
        logic [8:0] seq[7];
        clear_counters();
        seq = '{K28_7_SOF, 9'h0AA, 9'h0BB, K28_5_EOF, 9'h001, 9'h002, 9'h003};
        for (int i = 0; i < 7; i++) begin
            sym_step(seq[i], 1'b1);
            n_checks++;
            if (rec_bus.rec_valid !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL short_no_rec_%0d: valid=%0b required 0", i, rec_bus.rec_valid);
            end
        end
        n_checks++;
        if (frame_err_cnt !== 8'd1) begin
            n_errors++;
            $display("[TB] FAIL short_frame_err: got %0d required 1", frame_err_cnt);
        end
    endtask

    task automatic test_decode_error();
        clear_counters();
        sym_step(K28_7_SOF, 1'b1);
        sym_step(9'h001, 1'b1);
        step(1'b1, 1'b1, 9'h002, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int b = 3; b <= 5; b++) begin
            sym_step(9'(b), 1'b1);
            n_checks++;
            if (rec_bus.rec_valid !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL decerr_no_rec_%0d: valid=%0b required 0", b, rec_bus.rec_valid);
            end
        end
        n_checks++;
        if (dec_err_cnt !== 8'd1 || frame_err_cnt !== 8'd0) begin
            n_errors++;
            $display("[TB] FAIL decerr_cnt: dec=%0d frame=%0d required 1 0",
                     dec_err_cnt, frame_err_cnt);
        end
    endtask

    task automatic test_backpressure();
        clear_counters();
        sym_step(K28_7_SOF, 1'b0);
        for (int i = 0; i < 9; i++) sym_step(9'(8'h21 + 8'(i)), 1'b0);
        sym_step(K28_5_EOF, 1'b0);
        n_checks++;
        if (lost_cnt !== 8'd2) begin
            n_errors++;
            $display("[TB] FAIL bp_lost: got %0d required 2", lost_cnt);
        end
        n_checks++;
        if (rec_bus.rec_valid !== 1'b1 || rec_bus.rec_data !== 24'h212223 ||
            rec_bus.rec_first !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL bp_held: valid=%0b data=%06h first=%0b required 1 212223 1",
                     rec_bus.rec_valid, rec_bus.rec_data, rec_bus.rec_first);
        end
        idle_step(1'b1);
        n_checks++;
        if (rec_bus.rec_valid !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL bp_drained: valid=%0b required 0", rec_bus.rec_valid);
        end
    endtask

    task automatic test_saturation();
        clear_counters();
        sym_step(K28_7_SOF, 1'b1);
        for (int i = 0; i < 300; i++) sym_step(K28_7_SOF, 1'b1);
        n_checks++;
        if (frame_err_cnt !== 8'd255) begin
            n_errors++;
            $display("[TB] FAIL sat_frame: got %0d required 255", frame_err_cnt);
        end
        step(1'b1, 1'b1, K28_7_SOF, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (frame_err_cnt !== 8'd0) begin
            n_errors++;
            $display("[TB] FAIL clr_wins: got %0d required 0", frame_err_cnt);
        end
        sym_step(K28_5_EOF, 1'b1);
    endtask

    task automatic test_reset_midframe();
        sym_step(K28_7_SOF, 1'b0);
        sym_step(9'h0C1, 1'b0);
        sym_step(9'h0C2, 1'b0);
        sym_step(9'h0C3, 1'b0);
        sym_step(K28_5_EOF, 1'b0);
        sym_step(K28_7_SOF, 1'b0);
        sym_step(9'h010, 1'b0);
        rst_n = 1'b0;
        enable = 1'b1; sym_valid = 1'b0; rec_bus.rec_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if ({rec_bus.rec_valid, rec_bus.rec_first, rec_bus.rec_data} !== 26'h0 ||
            {dec_err_cnt, frame_err_cnt, lost_cnt} !== 24'h0) begin
            n_errors++;
            $display("[TB] FAIL midreset: valid=%0b data=%06h frame=%0d required all 0",
                     rec_bus.rec_valid, rec_bus.rec_data, frame_err_cnt);
        end
        rst_n = 1'b1;
        for (int b = 2; b <= 4; b++) begin
            sym_step(9'(b * 16), 1'b1);
            n_checks++;
            if (rec_bus.rec_valid !== 1'b0) begin
                n_errors++;
                $display("[TB] FAIL midreset_no_rec_%0d: valid=%0b required 0", b, rec_bus.rec_valid);
            end
        end
    endtask

    task automatic test_enable_low();
        clear_counters();
        sym_step(K28_7_SOF, 1'b1);
        sym_step(9'h0E1, 1'b1);
        step(1'b0, 1'b1, 9'h0E2, 1'b0, 1'b0, 1'b1, 1'b0);
        sym_step(9'h0E3, 1'b1);
        sym_step(9'h0E4, 1'b1);
        sym_step(9'h0E5, 1'b1);
        n_checks++;
        if (rec_bus.rec_valid !== 1'b0 || frame_err_cnt !== 8'd0) begin
            n_errors++;
            $display("[TB] FAIL enable_low: valid=%0b frame=%0d required 0 0",
                     rec_bus.rec_valid, frame_err_cnt);
        end
    endtask

    task automatic test_random();
        int local_err;
        local_err = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [8:0] sym;
            r = $urandom_range(0, 99);
            if (r < 10)      sym = K28_7_SOF;
            else if (r < 15) sym = K28_5_EOF;
            else if (r < 17) sym = K28_1_IDLE;
            else if (r < 18) sym = UNK_K;
            else             sym = {1'b0, 8'($urandom_range(0, 255))};
            step($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, sym,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
            n_checks++;
            if (rec_bus.rec_valid !== m_hold || rec_bus.rec_data !== m_rec_data ||
                rec_bus.rec_first !== m_rec_first) begin
                n_errors++;
                if (local_err++ < 10)
                    $display("[TB] FAIL rand_rec cyc %0d: valid=%0b data=%06h first=%0b required %0b %06h %0b",
                             c, rec_bus.rec_valid, rec_bus.rec_data, rec_bus.rec_first,
                             m_hold, m_rec_data, m_rec_first);
            end
            n_checks++;
            if (dec_err_cnt !== m_dec || frame_err_cnt !== m_frame || lost_cnt !== m_lost) begin
                n_errors++;
                if (local_err++ < 10)
                    $display("[TB] FAIL rand_cnt cyc %0d: dec=%0d frame=%0d lost=%0d required %0d %0d %0d",
                             c, dec_err_cnt, frame_err_cnt, lost_cnt, m_dec, m_frame, m_lost);
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_records();
        test_short_frame();
        test_decode_error();
        test_backpressure();
        test_saturation();
        test_reset_midframe();
        test_enable_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
